exc_redirect: RTL and testbench

Exception/return redirect controller: the consuming end of the coprocessor-0 exception interface. It accepts one exception request or one `eret` request from the memory stage, flushes the pipeline stages, and drives the target PC into fetch through a valid/ready handshake. It also returns the commit values (EPC, branch-delay flag, ExcCode, EXL set/clear) that the coprocessor-0 register file latches. It sits between the memory stage, the CP0 register block and the PC/fetch unit.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/exc_redirect_if.sv | 42 ++++
 rtl/exc_redirect.sv | 139 +++++++++++++
 tb/tb_exc_redirect.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CP0 ExcCode values, the exception entry vector and
// the redirect controller state encoding.
package cpu_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StFlush,
    StRedirect
  } redir_state_t;

  // Only address-error exceptions carry a meaningful BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_redirect_if.sv
// Signal bundle between the memory stage / CP0 / fetch and the exception
// redirect controller. The slave view belongs to the controller.
interface exc_redirect_if;

  logic        pause;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badva;
  logic        eret_req;
  logic [31:0] epc_in;
  logic        exl_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;
  logic        cp0_we;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [4:0]  cp0_code;
  logic        cp0_badva_we;
  logic [31:0] cp0_badva;
  logic        cp0_exl_set;
  logic        cp0_exl_clr;
  logic        busy;

  modport slave (
    input  pause, exc_req, exc_code, exc_pc, exc_in_ds, exc_badva,
    input  eret_req, epc_in, exl_in, redirect_ready,
    output redirect_valid, redirect_pc, flush, cp0_we, cp0_epc, cp0_bd,
    output cp0_code, cp0_badva_we, cp0_badva, cp0_exl_set, cp0_exl_clr, busy
  );

  modport master (
    output pause, exc_req, exc_code, exc_pc, exc_in_ds, exc_badva,
    output eret_req, epc_in, exl_in, redirect_ready,
    input  redirect_valid, redirect_pc, flush, cp0_we, cp0_epc, cp0_bd,
    input  cp0_code, cp0_badva_we, cp0_badva, cp0_exl_set, cp0_exl_clr, busy
  );

endinterface

// File: rtl/exc_redirect.sv
// Exception / eret redirect controller: commits CP0 state, flushes the
// pipeline, then hands the target PC to fetch. Every output is a flop.
module exc_redirect
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  exc_redirect_if.slave  bus
);

  redir_state_t state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  epc_q, epc_d;
  logic         bd_q, bd_d;
  logic [4:0]   code_q, code_d;
  logic [31:0]  badva_q, badva_d;
  logic         badva_we_q, badva_we_d;
  logic         exl_set_q, exl_set_d;
  logic         exl_clr_q, exl_clr_d;
  logic         we_q, we_d;
  logic         flush_q, flush_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    epc_d     = epc_q;
    bd_d      = bd_q;
    code_d    = code_q;
    badva_d   = badva_q;
    exl_set_d = exl_set_q;
    exl_clr_d = exl_clr_q;
    badva_we_d = 1'b0;

    if (!bus.pause) begin
      unique case (state_q)
        StIdle: begin
          if (bus.exc_req && !bus.exl_in) begin
            state_d   = StCommit;
            target_d  = EXC_VECTOR;
            epc_d     = bus.exc_in_ds ? (bus.exc_pc - 32'd4) : bus.exc_pc;
            bd_d      = bus.exc_in_ds;
            code_d    = bus.exc_code;
            exl_set_d = 1'b1;
            exl_clr_d = 1'b0;
            if (is_addr_exc(bus.exc_code)) begin
              badva_d    = bus.exc_badva;
              badva_we_d = 1'b1;
            end
          end else if (bus.eret_req) begin
            state_d   = StCommit;
            target_d  = bus.epc_in;
            exl_set_d = 1'b0;
            exl_clr_d = 1'b1;
          end
        end
        StCommit: begin
          if (FLUSH_CYCLES <= 1) begin
            state_d = StRedirect;
          end else begin
            state_d = StFlush;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
          end
        end
        StFlush: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = StRedirect;
            cnt_d   = 3'd0;
          end
        end
        StRedirect: begin
          if (bus.redirect_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // The strobe fires only on entry, so a stall inside COMMIT cannot repeat the write.
    we_d    = (state_d == StCommit) && (state_q == StIdle);
    flush_d = (state_d == StCommit) || (state_d == StFlush);
    valid_d = (state_d == StRedirect);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      target_q   <= 32'd0;
      epc_q      <= 32'd0;
      bd_q       <= 1'b0;
      code_q     <= 5'd0;
      badva_q    <= 32'd0;
      badva_we_q <= 1'b0;
      exl_set_q  <= 1'b0;
      exl_clr_q  <= 1'b0;
      we_q       <= 1'b0;
      flush_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      code_q     <= code_d;
      badva_q    <= badva_d;
      badva_we_q <= badva_we_d;
      exl_set_q  <= exl_set_d;
      exl_clr_q  <= exl_clr_d;
      we_q       <= we_d;
      flush_q    <= flush_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.redirect_valid = valid_q;
  assign bus.redirect_pc    = target_q;
  assign bus.flush          = flush_q;
  assign bus.cp0_we         = we_q;
  assign bus.cp0_epc        = epc_q;
  assign bus.cp0_bd         = bd_q;
  assign bus.cp0_code       = code_q;
  assign bus.cp0_badva_we   = badva_we_q;
  assign bus.cp0_badva      = badva_q;
  assign bus.cp0_exl_set    = exl_set_q;
  assign bus.cp0_exl_clr    = exl_clr_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_exc_redirect.sv
// Scoreboard bench for exc_redirect: stimulus pushes expected commits and
// redirects; a negedge monitor pops and compares them as the DUT emits them.
module tb_exc_redirect;

  logic clk;
  logic rst_n;
  exc_redirect_if bus();

  exc_redirect #(
    .EXC_VECTOR   (32'hBFC0_0380),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] epc;
    logic        bd;
    logic [4:0]  code;
    logic        cause;   // check epc/bd/code (exceptions only)
    logic        set;
    logic        clr;
    logic        bwe;
    logic [31:0] badva;
  } commit_t;

  typedef struct {
    logic [31:0] pc;
    int          flushes;
  } redir_t;

  commit_t cq[$];
  redir_t  rq[$];
  int n_vec = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int flush_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cp0_we) begin
        we_cnt++;
        flush_cnt = 0;
        if (cq.size() == 0) begin
          chk("unexpected_commit", 32'd1, 32'd0);
        end else begin
          commit_t c;
          c = cq.pop_front();
          if (c.cause) begin
            chk("cp0_epc", bus.cp0_epc, c.epc);
            chk("cp0_bd", {31'd0, bus.cp0_bd}, {31'd0, c.bd});
            chk("cp0_code", {27'd0, bus.cp0_code}, {27'd0, c.code});
          end
          chk("cp0_exl_set", {31'd0, bus.cp0_exl_set}, {31'd0, c.set});
          chk("cp0_exl_clr", {31'd0, bus.cp0_exl_clr}, {31'd0, c.clr});
          chk("cp0_badva_we", {31'd0, bus.cp0_badva_we}, {31'd0, c.bwe});
          if (c.bwe) chk("cp0_badva", bus.cp0_badva, c.badva);
        end
      end
      if (bus.flush && !bus.pause) flush_cnt++;
      if (bus.redirect_valid && bus.redirect_ready) begin
        if (rq.size() == 0) begin
          chk("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          redir_t r;
          r = rq.pop_front();
          chk("redirect_pc", bus.redirect_pc, r.pc);
          chk("flush_cycles", 32'(flush_cnt), 32'(r.flushes));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.pause = 0; bus.exc_req = 0; bus.exc_code = 0; bus.exc_pc = 0;
    bus.exc_in_ds = 0; bus.exc_badva = 0; bus.eret_req = 0; bus.epc_in = 0;
    bus.exl_in = 0; bus.redirect_ready = 1;
  endtask

  // Drive request for one sampling edge; returns #1 after that edge.
  task automatic issue(input logic exc, input logic eret, input logic [4:0] code,
                       input logic [31:0] pc, input logic ds, input logic [31:0] badva,
                       input logic [31:0] epc_in);
    @(posedge clk); #1;
    bus.exc_req = exc; bus.eret_req = eret; bus.exc_code = code; bus.exc_pc = pc;
    bus.exc_in_ds = ds; bus.exc_badva = badva; bus.epc_in = epc_in;
    @(posedge clk); #1;
    bus.exc_req = 0; bus.eret_req = 0;
  endtask

  task automatic push(input commit_t c, input logic [31:0] pc);
    redir_t r;
    cq.push_back(c);
    r.pc = pc; r.flushes = 2;
    rq.push_back(r);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    if (i == 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_flush"}, {31'd0, bus.flush}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.cp0_we}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, "_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, "_epc"}, bus.cp0_epc, 32'd0);
    chk({tag, "_set"}, {31'd0, bus.cp0_exl_set}, 32'd0);
  endtask

  initial begin
    commit_t c;
    int w0;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1;

    // Syscall, not in a delay slot; also check cycle timing
    c = '{epc: 32'hBFC0_1000, bd: 0, code: 5'd8, cause: 1, set: 1, clr: 0, bwe: 0, badva: 0};
    push(c, 32'hBFC0_0380);
    issue(1, 0, 5'd8, 32'hBFC0_1000, 0, 0, 0);
    @(negedge clk);
    chk("t1_c1_flush", {31'd0, bus.flush}, 32'd1);
    @(negedge clk);
    chk("t1_c2_flush", {31'd0, bus.flush}, 32'd1);
    chk("t1_c2_valid", {31'd0, bus.redirect_valid}, 32'd0);
    @(negedge clk);
    chk("t1_c3_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t1_c3_flush", {31'd0, bus.flush}, 32'd0);
    wait_idle();

    // AdEL in delay slot
    c = '{epc: 32'h8000_0020, bd: 1, code: 5'd4, cause: 1, set: 1, clr: 0, bwe: 1,
          badva: 32'h8000_0031};
    push(c, 32'hBFC0_0380);
    issue(1, 0, 5'd4, 32'h8000_0024, 1, 32'h8000_0031, 0);
    wait_idle();

    // Eret
    c = '{epc: 0, bd: 0, code: 0, cause: 0, set: 0, clr: 1, bwe: 0, badva: 0};
    push(c, 32'hBFC0_2004);
    issue(0, 1, 5'd0, 0, 0, 0, 32'hBFC0_2004);
    wait_idle();

    // Both requests: exception wins; PC 0 in delay slot wraps
    c = '{epc: 32'hFFFF_FFFC, bd: 1, code: 5'd12, cause: 1, set: 1, clr: 0, bwe: 0, badva: 0};
    push(c, 32'hBFC0_0380);
    issue(1, 1, 5'd12, 32'h0000_0000, 1, 32'h1111_1111, 32'h0000_1234);
    wait_idle();

    // Exception while EXL=1 is ignored
    @(posedge clk); #1;
    bus.exl_in = 1; bus.exc_req = 1; bus.exc_code = 5'd10; bus.exc_pc = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exl_mask_busy", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clk); #1;
    bus.exl_in = 0; bus.exc_req = 0;

    // Backpressure: held stable while not ready
    bus.redirect_ready = 0;
    c = '{epc: 32'h8000_1000, bd: 0, code: 5'd10, cause: 1, set: 1, clr: 0, bwe: 0, badva: 0};
    push(c, 32'hBFC0_0380);
    issue(1, 0, 5'd10, 32'h8000_1000, 0, 0, 0);
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.redirect_valid) break;
      end
      if (i == 20) chk("valid_timeout", 32'd1, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, bus.redirect_valid}, 32'd1);
      chk("bp_pc", bus.redirect_pc, 32'hBFC0_0380);
      @(negedge clk);
    end
    #1 bus.redirect_ready = 1;
    wait_idle();

    // Pause for 3 cycles while in COMMIT: one write, two unpaused flush cycles
    w0 = we_cnt;
    c = '{epc: 32'h8000_2000, bd: 0, code: 5'd9, cause: 1, set: 1, clr: 0, bwe: 0, badva: 0};
    push(c, 32'hBFC0_0380);
    issue(1, 0, 5'd9, 32'h8000_2000, 0, 0, 0);
    bus.pause = 1;
    repeat (3) @(posedge clk);
    #1 bus.pause = 0;
    wait_idle();
    chk("pause_we_pulses", 32'(we_cnt - w0), 32'd1);

    // Reset asserted mid-FLUSH
    c = '{epc: 32'h8000_3000, bd: 0, code: 5'd8, cause: 1, set: 1, clr: 0, bwe: 0, badva: 0};
    push(c, 32'hBFC0_0380);
    issue(1, 0, 5'd8, 32'h8000_3000, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_flush", {31'd0, bus.flush}, 32'd1);
    #2 rst_n = 0;
    #1 check_zero("midrst");
    cq.delete();
    rq.delete();
    @(posedge clk); #1 rst_n = 1;

    // Accepted normally after reset
    c = '{epc: 0, bd: 0, code: 0, cause: 0, set: 0, clr: 1, bwe: 0, badva: 0};
    push(c, 32'h8000_4000);
    issue(0, 1, 5'd0, 0, 0, 0, 32'h8000_4000);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("commit_queue_empty", 32'(cq.size()), 32'd0);
    chk("redirect_queue_empty", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
